// File: rtl/clk_div_bank.sv
// Bank of independent integer clock dividers with per-channel start/stop,
// deferred ratio reloads at period boundaries and a global phase-realign strobe.
module clk_div_bank #(
    parameter int NCH         = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*DIV_W-1:0] div_val,
    input  logic                 load,
    input  logic                 sync,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       running
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DEF_RAW   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RESET_DIV = (DEF_RAW < DIV_W'(2)) ? DIV_W'(2) : DEF_RAW;

    // Ratios below 2 cannot form a high and a low phase, so they become 2.
    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] v);
        if (v < DIV_W'(2)) begin
            return DIV_W'(2);
        end else begin
            return v;
        end
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [DIV_W-1:0] r_n;
        logic [DIV_W-1:0] r_p;
        logic [DIV_W-1:0] r_cnt;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;
        logic             r_run;
        logic [DIV_W-1:0] w_p_eff;
        logic [DIV_W-1:0] w_n_eff;
        logic [DIV_W-1:0] w_cnt_nxt;
        logic             w_pend_eff;
        logic             w_idle;
        logic             w_boundary;
        logic             w_apply;

        // Next-state, effective ratio and next count for this channel.
        always_comb begin
            w_idle     = (r_state == ST_IDLE);
            w_p_eff    = load ? clamp_ratio(div_val[g*DIV_W +: DIV_W]) : r_p;
            w_pend_eff = load | r_pend;
            w_boundary = (r_cnt == (r_n - DIV_W'(1)));
            // Idle channels, sync restarts and period ends are the only points a new ratio may land.
            w_apply    = w_pend_eff & (w_idle | sync | w_boundary);
            w_n_eff    = w_apply ? w_p_eff : r_n;
            if (w_idle || sync || w_boundary) begin
                w_cnt_nxt = DIV_W'(0);
            end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = en[g] ? ST_RUN : ST_IDLE;
                end
                ST_RUN, ST_STOPPING: begin
                    if (sync) begin
                        w_state_nxt = en[g] ? ST_RUN : ST_STOPPING;
                    end else if (w_boundary && !en[g]) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = en[g] ? ST_RUN : ST_STOPPING;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Channel state, ratio registers and registered waveform outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_n     <= RESET_DIV;
                r_p     <= RESET_DIV;
                r_pend  <= 1'b0;
                r_cnt   <= DIV_W'(0);
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
                r_run   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_n     <= w_n_eff;
                r_p     <= w_p_eff;
                r_pend  <= w_pend_eff & ~w_apply;
                if (w_state_nxt != ST_IDLE) begin
                    r_cnt  <= w_cnt_nxt;
                    r_clk  <= (w_cnt_nxt < (w_n_eff >> 1));
                    r_tick <= (w_cnt_nxt == DIV_W'(0));
                    r_run  <= 1'b1;
                end else begin
                    r_cnt  <= DIV_W'(0);
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    r_run  <= 1'b0;
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign running[g] = r_run;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: period-position reference model compared
// every cycle, plus directed waveform patterns with literal expectations.
module tb_clk_div_bank;
    localparam int NCH         = 4;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load;
    logic                 sync;
    logic [NCH-1:0]       en;
    logic [NCH*DIV_W-1:0] div_val;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       running;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NCH        (NCH),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .div_val(div_val),
        .load   (load),
        .sync   (sync),
        .clk_out(clk_out),
        .tick   (tick),
        .running(running)
    );

    // Reference: each live channel sits at a position within an N-cycle period.
    int             m_n     [NCH];
    int             m_p     [NCH];
    int             m_pos   [NCH];
    bit             m_pend  [NCH];
    bit             m_alive [NCH];
    bit             m_valid = 1'b0;
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_run;

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_step();
        int lp;
        bit lpend;
        bit ap;
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                m_n[i]     = clampv(DEFAULT_DIV);
                m_p[i]     = m_n[i];
                m_pend[i]  = 1'b0;
                m_alive[i] = 1'b0;
                m_pos[i]   = 0;
            end else begin
                lp    = load ? clampv(32'(div_val[i*DIV_W +: DIV_W])) : m_p[i];
                lpend = load || m_pend[i];
                ap    = 1'b0;
                if (!m_alive[i]) begin
                    ap = lpend;
                    if (en[i]) begin
                        m_alive[i] = 1'b1;
                        m_pos[i]   = 0;
                    end
                end else if (sync) begin
                    ap       = lpend;
                    m_pos[i] = 0;
                end else if (m_pos[i] == m_n[i] - 1) begin
                    ap       = lpend;
                    m_pos[i] = 0;
                    if (!en[i]) m_alive[i] = 1'b0;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
                if (ap) m_n[i] = lp;
                m_p[i]    = lp;
                m_pend[i] = lpend && !ap;
            end
            exp_clk[i]  = m_alive[i] && (m_pos[i] < m_n[i] / 2);
            exp_tick[i] = m_alive[i] && (m_pos[i] == 0);
            exp_run[i]  = m_alive[i];
        end
        m_valid = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_clk_out", 32'(clk_out), 32'(exp_clk));
            check("model_tick",    32'(tick),    32'(exp_tick));
            check("model_running", 32'(running), 32'(exp_run));
        end
    end

    task automatic step();
        @(negedge clk);
        load = 1'b0;
        sync = 1'b0;
    endtask

    // Patterns are read MSB first, one bit per observed cycle.
    task automatic expect_wave(input string name, input int ch, input int len,
                               input logic [15:0] clk_pat, input logic [15:0] tick_pat,
                               input logic [15:0] run_pat);
        for (int j = 0; j < len; j++) begin
            step();
            check({name, "_clk"},  32'(clk_out[ch]), 32'(clk_pat[len-1-j]));
            check({name, "_tick"}, 32'(tick[ch]),    32'(tick_pat[len-1-j]));
            check({name, "_run"},  32'(running[ch]), 32'(run_pat[len-1-j]));
        end
    endtask

    logic [5:0] pa;
    logic [5:0] pb;

    initial begin
        rst     = 1'b1;
        en      = '0;
        load    = 1'b0;
        sync    = 1'b0;
        div_val = {16'd4, 16'd4, 16'd4, 16'd4};
        repeat (3) step();
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_tick",    32'(tick),    32'd0);
        check("reset_running", 32'(running), 32'd0);
        rst = 1'b0;

        en[0] = 1'b1;
        expect_wave("default_n4", 0, 12, 16'b110011001100, 16'b100010001000, 16'hffff);

        div_val[1*DIV_W +: DIV_W] = 16'd5;
        load = 1'b1;
        step();
        en[1] = 1'b1;
        expect_wave("idle_load_n5", 1, 10, 16'b1100011000, 16'b1000010000, 16'hffff);

        div_val[1*DIV_W +: DIV_W] = 16'd6;
        load = 1'b1;
        repeat (12) step();
        sync = 1'b1;
        step();
        check("sync_clk", 32'(clk_out[1:0]), 32'd3);
        check("sync_tick", 32'(tick[1:0]),   32'd3);
        pa = 6'b100110;
        pb = 6'b110001;
        for (int j = 0; j < 6; j++) begin
            step();
            check("after_sync_ch0", 32'(clk_out[0]), 32'(pa[5-j]));
            check("after_sync_ch1", 32'(clk_out[1]), 32'(pb[5-j]));
        end

        sync = 1'b1;
        step();
        step();
        div_val[0*DIV_W +: DIV_W] = 16'd6;
        load = 1'b1;
        expect_wave("deferred_n6", 0, 9, 16'b001110001, 16'b001000001, 16'hffff);

        en = '0;
        repeat (14) step();
        check("all_stopped", 32'(running), 32'd0);
        div_val[0*DIV_W +: DIV_W] = 16'd4;
        load = 1'b1;
        step();
        en[0] = 1'b1;
        step();
        check("first_high", 32'(clk_out[0]), 32'd1);
        en[0] = 1'b0;
        expect_wave("stop_drain", 0, 6, 16'b100000, 16'b000000, 16'b111000);

        div_val[0*DIV_W +: DIV_W] = 16'd0;
        load = 1'b1;
        step();
        en[0] = 1'b1;
        expect_wave("ratio0_as_2", 0, 4, 16'b1010, 16'b1010, 16'b1111);
        step();
        check("pre_rst_high", 32'(clk_out[0]), 32'd1);
        rst = 1'b1;
        step();
        check("rst_mid_clk",  32'(clk_out), 32'd0);
        check("rst_mid_tick", 32'(tick),    32'd0);
        check("rst_mid_run",  32'(running), 32'd0);
        rst = 1'b0;
        expect_wave("post_rst_n4", 0, 6, 16'b110011, 16'b100010, 16'b111111);

        en[2] = 1'b1;
        sync  = 1'b1;
        expect_wave("start_with_sync", 2, 4, 16'b1100, 16'b1000, 16'b1111);

        div_val = {16'd4, 16'd3, 16'd6, 16'd5};
        load = 1'b1;
        sync = 1'b1;
        expect_wave("sync_load_n3", 2, 4, 16'b1001, 16'b1001, 16'b1111);

        en[2] = 1'b0;
        step();
        en[2] = 1'b1;
        repeat (6) step();
        en = '0;
        repeat (12) step();
        check("final_idle", 32'(running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
